// File: rtl/parity_check_stream.sv
// Streaming per-lane parity checker with a one-entry result register, saturating
// word/error counters, a sticky error flag and a first-error capture.

module parity_check_lane #(
    parameter int LANE_W = 16
) (
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_parity,
    input  logic              i_oddMode,
    output logic              o_err
);
    // Odd mode inverts the even-mode result, so fold it into the XOR tree.
    assign o_err = (^i_lane) ^ i_parity ^ i_oddMode;
endmodule

module parity_check_stream #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] inData,
    input  logic [LANES-1:0]      inParity,
    input  logic                  oddMode,
    input  logic                  clearCounts,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [LANES-1:0]      outLaneError,
    output logic                  outError,
    output logic [CNT_WIDTH-1:0]  wordCount,
    output logic [CNT_WIDTH-1:0]  errorCount,
    output logic                  stickyError,
    output logic [CNT_WIDTH-1:0]  firstErrWord,
    output logic [LANES-1:0]      firstErrLanes
);
    localparam int LW = DATA_WIDTH / LANES;

    logic                  r_outValid;
    logic [DATA_WIDTH-1:0] r_outData;
    logic [LANES-1:0]      r_outLaneError;
    logic                  r_outError;
    logic [CNT_WIDTH-1:0]  r_wordCount;
    logic [CNT_WIDTH-1:0]  r_errorCount;
    logic                  r_stickyError;
    logic [CNT_WIDTH-1:0]  r_firstErrWord;
    logic [LANES-1:0]      r_firstErrLanes;
    logic                  r_firstErrSeen;

    logic [LANES-1:0]      w_laneErr;
    logic                  w_anyErr;
    logic                  w_accept;
    logic                  w_errAccept;
    logic [CNT_WIDTH-1:0]  w_wcBase;
    logic [CNT_WIDTH-1:0]  w_ecBase;
    logic                  w_stickyBase;
    logic                  w_seenBase;
    logic [CNT_WIDTH-1:0]  w_wcInc;
    logic [CNT_WIDTH-1:0]  w_ecInc;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        parity_check_lane #(.LANE_W(LW)) u_lane (
            .i_lane    (inData[k*LW +: LW]),
            .i_parity  (inParity[k]),
            .i_oddMode (oddMode),
            .o_err     (w_laneErr[k])
        );
    end

    assign inReady     = ~r_outValid | outReady;
    assign w_accept    = inValid & inReady;
    assign w_anyErr    = |w_laneErr;
    assign w_errAccept = w_accept & w_anyErr;

    // Clear is applied before the accepted word is counted, so the update
    // starts from zeroed state whenever clearCounts is high.
    assign w_wcBase     = clearCounts ? '0   : r_wordCount;
    assign w_ecBase     = clearCounts ? '0   : r_errorCount;
    assign w_stickyBase = clearCounts ? 1'b0 : r_stickyError;
    assign w_seenBase   = clearCounts ? 1'b0 : r_firstErrSeen;
    assign w_wcInc      = (&w_wcBase) ? w_wcBase : w_wcBase + CNT_WIDTH'(1);
    assign w_ecInc      = (&w_ecBase) ? w_ecBase : w_ecBase + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid      <= 1'b0;
            r_outData       <= '0;
            r_outLaneError  <= '0;
            r_outError      <= 1'b0;
            r_wordCount     <= '0;
            r_errorCount    <= '0;
            r_stickyError   <= 1'b0;
            r_firstErrWord  <= '0;
            r_firstErrLanes <= '0;
            r_firstErrSeen  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_outValid     <= 1'b1;
                r_outData      <= inData;
                r_outLaneError <= w_laneErr;
                r_outError     <= w_anyErr;
            end else if (outReady) begin
                r_outValid     <= 1'b0;
            end

            if (clearCounts || w_accept) begin
                r_wordCount   <= w_accept ? w_wcInc : w_wcBase;
                r_errorCount  <= w_errAccept ? w_ecInc : w_ecBase;
                r_stickyError <= w_stickyBase | w_errAccept;
                if (w_errAccept && !w_seenBase) begin
                    r_firstErrWord  <= w_wcBase;
                    r_firstErrLanes <= w_laneErr;
                    r_firstErrSeen  <= 1'b1;
                end else if (clearCounts) begin
                    r_firstErrWord  <= '0;
                    r_firstErrLanes <= '0;
                    r_firstErrSeen  <= 1'b0;
                end
            end
        end
    end

    assign outValid      = r_outValid;
    assign outData       = r_outData;
    assign outLaneError  = r_outLaneError;
    assign outError      = r_outError;
    assign wordCount     = r_wordCount;
    assign errorCount    = r_errorCount;
    assign stickyError   = r_stickyError;
    assign firstErrWord  = r_firstErrWord;
    assign firstErrLanes = r_firstErrLanes;
endmodule

// File: tb/tb_parity_check_stream.sv
// Bench for parity_check_stream: directed scenarios plus a randomized stream,
// checked against a transaction-level model; a 4-bit-counter instance covers saturation.

module tb_parity_check_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic [63:0] inData = '0;
    logic [3:0]  inParity = '0;
    logic        oddMode = 1'b0;
    logic        clearCounts = 1'b0;
    logic        outReady = 1'b1;

    logic        inReady, outValid, outError, stickyError;
    logic [63:0] outData;
    logic [3:0]  outLaneError, firstErrLanes;
    logic [15:0] wordCount, errorCount, firstErrWord;

    logic        inReady_s, outValid_s, outError_s, stickyError_s;
    logic [63:0] outData_s;
    logic [3:0]  outLaneError_s, firstErrLanes_s;
    logic [3:0]  wordCount_s, errorCount_s, firstErrWord_s;

    int tot = 0;
    int bad = 0;

    // model state
    logic        m_ov;
    logic [63:0] m_od;
    logic [3:0]  m_ol, m_fel;
    logic        m_st, m_seen;
    int          m_wc16, m_ec16, m_few16, m_wc4, m_ec4, m_few4;

    always #5 clk = ~clk;

    parity_check_stream #(.DATA_WIDTH(64), .LANES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inData(inData), .inParity(inParity), .oddMode(oddMode),
        .clearCounts(clearCounts), .outValid(outValid), .outReady(outReady),
        .outData(outData), .outLaneError(outLaneError), .outError(outError),
        .wordCount(wordCount), .errorCount(errorCount), .stickyError(stickyError),
        .firstErrWord(firstErrWord), .firstErrLanes(firstErrLanes)
    );

    parity_check_stream #(.DATA_WIDTH(64), .LANES(4), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady_s),
        .inData(inData), .inParity(inParity), .oddMode(oddMode),
        .clearCounts(clearCounts), .outValid(outValid_s), .outReady(outReady),
        .outData(outData_s), .outLaneError(outLaneError_s), .outError(outError_s),
        .wordCount(wordCount_s), .errorCount(errorCount_s), .stickyError(stickyError_s),
        .firstErrWord(firstErrWord_s), .firstErrLanes(firstErrLanes_s)
    );

    // A lane is in error when its count of ones (data plus parity bit) is odd
    // in even mode, or even in odd mode.
    function automatic logic [3:0] lane_err(input logic [63:0] d, input logic [3:0] p,
                                            input logic odd);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            int n;
            logic [15:0] lane;
            lane = d[k*16 +: 16];
            n = $countones(lane) + int'(p[k]);
            e[k] = odd ? (n % 2 == 0) : (n % 2 == 1);
        end
        return e;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_od = '0; m_ol = '0; m_fel = '0; m_st = 0; m_seen = 0;
        m_wc16 = 0; m_ec16 = 0; m_few16 = 0; m_wc4 = 0; m_ec4 = 0; m_few4 = 0;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, and
    // returns #1 after the edge with outputs ready to sample.
    task automatic cyc(input logic v, input logic [63:0] d, input logic [3:0] p,
                       input logic odd, input logic clr, input logic rdy);
        logic acc;
        logic [3:0] le;
        @(negedge clk);
        inValid = v; inData = d; inParity = p; oddMode = odd;
        clearCounts = clr; outReady = rdy;
        acc = v && (!m_ov || rdy);
        @(posedge clk);
        if (clr) begin
            m_wc16 = 0; m_ec16 = 0; m_few16 = 0; m_wc4 = 0; m_ec4 = 0; m_few4 = 0;
            m_st = 0; m_seen = 0; m_fel = '0;
        end
        if (acc) begin
            le = lane_err(d, p, odd);
            m_ov = 1; m_od = d; m_ol = le;
            if (le != 0) begin
                if (!m_seen) begin
                    m_seen = 1; m_fel = le; m_few16 = m_wc16; m_few4 = m_wc4;
                end
                m_st = 1;
                m_ec16 = sat(m_ec16, 65535);
                m_ec4 = sat(m_ec4, 15);
            end
            m_wc16 = sat(m_wc16, 65535);
            m_wc4 = sat(m_wc4, 15);
        end else if (rdy) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        #3;
        tot++;
        if (inReady !== 1'b1) begin bad++; $display("FAIL reset_inready got=%b exp=1", inReady); end
        repeat (2) @(posedge clk);
        #1;
        tot++;
        if ({outValid, outData, outLaneError, outError} !== '0) begin
            bad++; $display("FAIL reset_out got=%b/%h/%b/%b exp=0", outValid, outData, outLaneError, outError);
        end
        tot++;
        if ({wordCount, errorCount, stickyError, firstErrWord, firstErrLanes} !== '0) begin
            bad++; $display("FAIL reset_cnt got=%h/%h/%b/%h/%b exp=0", wordCount, errorCount,
                            stickyError, firstErrWord, firstErrLanes);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_all_ones();
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 0, 0, 1);
        tot++;
        if ({outValid, outLaneError, outError} !== {1'b1, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL ones_out got=%b/%b/%b exp=1/0000/0", outValid, outLaneError, outError);
        end
        tot++;
        if (wordCount !== 16'd1 || errorCount !== 16'd0) begin
            bad++; $display("FAIL ones_cnt got=%0d/%0d exp=1/0", wordCount, errorCount);
        end
    endtask

    task automatic test_even_err();
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 0, 0, 1);
        tot++;
        if (outLaneError !== 4'b0001 || outError !== 1'b1) begin
            bad++; $display("FAIL even_lane got=%b/%b exp=0001/1", outLaneError, outError);
        end
        tot++;
        if (errorCount !== 16'd1 || stickyError !== 1'b1) begin
            bad++; $display("FAIL even_cnt got=%0d/%b exp=1/1", errorCount, stickyError);
        end
        tot++;
        if (firstErrWord !== 16'd1 || firstErrLanes !== 4'b0001) begin
            bad++; $display("FAIL even_first got=%0d/%b exp=1/0001", firstErrWord, firstErrLanes);
        end
    endtask

    task automatic test_odd();
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1, 0, 1);
        tot++;
        if (outLaneError !== 4'b1111) begin
            bad++; $display("FAIL odd_all got=%b exp=1111", outLaneError);
        end
        cyc(1, 64'h0000_0000_0000_0001, 4'b1110, 1, 0, 1);
        tot++;
        if (outLaneError !== 4'b0000 || outError !== 1'b0) begin
            bad++; $display("FAIL odd_clean got=%b/%b exp=0000/0", outLaneError, outError);
        end
        tot++;
        if (firstErrWord !== 16'd1 || errorCount !== 16'd2) begin
            bad++; $display("FAIL odd_first got=%0d/%0d exp=1/2", firstErrWord, errorCount);
        end
        cyc(0, '0, '0, 0, 0, 1);
        tot++;
        if (outValid !== 1'b0 || outData !== 64'h1) begin
            bad++; $display("FAIL odd_drain got=%b/%h exp=0/1", outValid, outData);
        end
    endtask

    task automatic test_backpressure();
        int wc0;
        wc0 = m_wc16;
        cyc(1, 64'hA5A5_0000_1234_5678, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 64'hDEAD_BEEF_CAFE_F00D, 4'b0101, 0, 0, 0);
            tot++;
            if (inReady !== 1'b0 || outValid !== 1'b1 || outData !== 64'hA5A5_0000_1234_5678) begin
                bad++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/a5a5000012345678",
                                inReady, outValid, outData);
            end
            tot++;
            if (wordCount !== 16'(wc0 + 1)) begin
                bad++; $display("FAIL bp_count got=%0d exp=%0d", wordCount, wc0 + 1);
            end
        end
        cyc(1, 64'hDEAD_BEEF_CAFE_F00D, 4'b0101, 0, 0, 1);
        tot++;
        if (outData !== 64'hDEAD_BEEF_CAFE_F00D || wordCount !== 16'(wc0 + 2)) begin
            bad++; $display("FAIL bp_release got=%h/%0d exp=deadbeefcafef00d/%0d",
                            outData, wordCount, wc0 + 2);
        end
    endtask

    task automatic test_clear();
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 0, 1, 1);
        tot++;
        if (wordCount !== 16'd1 || errorCount !== 16'd1 || stickyError !== 1'b1) begin
            bad++; $display("FAIL clr_cnt got=%0d/%0d/%b exp=1/1/1", wordCount, errorCount, stickyError);
        end
        tot++;
        if (firstErrWord !== 16'd0 || firstErrLanes !== 4'b0100) begin
            bad++; $display("FAIL clr_first got=%0d/%b exp=0/0100", firstErrWord, firstErrLanes);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            cyc(($urandom_range(0, 3) != 0), d, 4'($urandom), 1'($urandom),
                ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0));
            tot++;
            if ({outValid, outData, outLaneError, outError} !== {m_ov, m_od, m_ol, (m_ol != 0)}) begin
                bad++; $display("FAIL rnd_out i=%0d got=%b/%h/%b exp=%b/%h/%b", i, outValid,
                                outData, outLaneError, m_ov, m_od, m_ol);
            end
            tot++;
            if ({wordCount, errorCount, stickyError} !== {16'(m_wc16), 16'(m_ec16), m_st}) begin
                bad++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, wordCount,
                                errorCount, stickyError, m_wc16, m_ec16, m_st);
            end
            tot++;
            if ({firstErrWord, firstErrLanes} !== {16'(m_few16), m_fel}) begin
                bad++; $display("FAIL rnd_first i=%0d got=%0d/%b exp=%0d/%b", i, firstErrWord,
                                firstErrLanes, m_few16, m_fel);
            end
            tot++;
            if ({wordCount_s, errorCount_s, firstErrWord_s} !== {4'(m_wc4), 4'(m_ec4), 4'(m_few4)}) begin
                bad++; $display("FAIL rnd_cnt4 i=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, wordCount_s,
                                errorCount_s, firstErrWord_s, m_wc4, m_ec4, m_few4);
            end
        end
    endtask

    task automatic test_saturation_reset();
        cyc(0, '0, '0, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1, {$urandom, $urandom}, 4'($urandom), 1'($urandom), 0, 1);
            if (outError !== 1'b1) begin
                // Force an error by flipping lane 0's parity if the random word was clean.
                cyc(1, m_od, m_ol ^ 4'b0001 ^ inParity, oddMode, 0, 1);
            end
        end
        tot++;
        if (wordCount_s !== 4'd15 || errorCount_s !== 4'd15) begin
            bad++; $display("FAIL sat_4 got=%0d/%0d exp=15/15", wordCount_s, errorCount_s);
        end
        tot++;
        if (wordCount !== 16'(m_wc16) || errorCount !== 16'(m_ec16) || m_ec16 < 20) begin
            bad++; $display("FAIL sat_16 got=%0d/%0d exp=%0d/%0d", wordCount, errorCount, m_wc16, m_ec16);
        end
        @(negedge clk);
        inValid = 1'b1; outReady = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        tot++;
        if ({outValid, outData, outLaneError, outError, wordCount, errorCount, stickyError,
             firstErrWord, firstErrLanes} !== '0 || inReady !== 1'b1) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%0d/%0d/%b rdy=%b exp=0 rdy=1",
                            outValid, outData, wordCount, errorCount, stickyError, inReady);
        end
        tot++;
        if ({outValid_s, wordCount_s, errorCount_s, stickyError_s} !== '0) begin
            bad++; $display("FAIL mid_reset4 got=%b/%0d/%0d/%b exp=0", outValid_s, wordCount_s,
                            errorCount_s, stickyError_s);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_all_ones();
                test_even_err();
                test_odd();
                test_backpressure();
                test_clear();
                test_random();
                test_saturation_reset();
            end
            begin
                #500000;
                tot++; bad++;
                $display("FAIL timeout got=running exp=done");
            end
        join_any
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/parity_check_stream.md
# parity_check_stream

Streaming, parametrised parity checker for the receive datapath. Each accepted word is split into LANES equal lanes. Every lane is checked against its own received parity bit, in even or odd mode selected per word. The block registers the word with per-lane error flags behind a valid/ready handshake, and keeps saturating word/error counters, a sticky error flag and a first-error capture for status readout.

## Interface
- DATA_WIDTH, 64, total data bits per word; must be an integer multiple of LANES
- LANES, 4, number of parity lanes; lane k = inData[(k+1)*DATA_WIDTH/LANES-1 : k*DATA_WIDTH/LANES]
- CNT_WIDTH, 16, width of wordCount, errorCount and firstErrWord
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- inValid  input  1  upstream word valid
- inReady  output  1  block can accept a word this cycle
- inData  input  DATA_WIDTH  received data
- inParity  input  LANES  received parity bit per lane
- oddMode  input  1  0 = even parity, 1 = odd parity; sampled with the word
- clearCounts  input  1  synchronous clear of counters, sticky flag and first-error capture
- outValid  output  1  registered result valid
- outReady  input  1  downstream accepts result
- outData  output  DATA_WIDTH  registered copy of accepted inData
- outLaneError  output  LANES  per-lane error for the word in outData
- outError  output  1  OR of outLaneError
- wordCount  output  CNT_WIDTH  accepted words, saturating
- errorCount  output  CNT_WIDTH  accepted words with outError = 1, saturating
- stickyError  output  1  set by any errored word, held until clear or reset
- firstErrWord  output  CNT_WIDTH  wordCount value (pre-increment) of the first errored word since clear
- firstErrLanes  output  LANES  lane-error vector of that first errored word

## Operation
- Accept = inValid & inReady. inReady = ~outValid | outReady. This makes a one-entry pipeline that sustains full throughput.
- Lane error k, even mode: (^lane k) ^ inParity[k].
- Lane error k, odd mode: ~((^lane k) ^ inParity[k]).
- On accept:
  - outData, outLaneError and outError load; outValid = 1.
  - wordCount += 1.
  - If any lane error: errorCount += 1 and stickyError = 1.
  - If any lane error and this is the first error since clear: firstErrWord = current wordCount and firstErrLanes = lane vector. The first-error status is tracked by an internal flag, firstErrSeen.
- When outValid & outReady with no accept that cycle: outValid = 0. Output data holds its last value.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap. Saturation of wordCount does not stop error counting.
- clearCounts and accept in the same cycle: the clear applies first and the accepted word is then counted. Results:
  - wordCount = 1.
  - errorCount = outError.
  - stickyError = outError.
  - The first-error capture is taken from this word if it is errored, with firstErrWord = 0.
- clearCounts does not affect outValid, outData or outLaneError.
- oddMode and inParity changes while no word is accepted have no effect.

## Timing
- Reset values: outValid 0, outData 0, outLaneError 0, outError 0, wordCount 0, errorCount 0, stickyError 0, firstErrWord 0, firstErrLanes 0, firstErrSeen 0. inReady reads 1 during and after reset.
- Latency: 1 cycle. A word accepted at edge N appears on outputs after edge N, and counters reflect it in the same cycle.
- Backpressure: while outValid = 1 and outReady = 0, inReady = 0. outData, outLaneError and outValid hold stable.
- Back-to-back: with outReady held at 1, one word is accepted every cycle.
- inReady is combinational from outValid and outReady. No other combinational input-to-output paths.
- Reset asserted mid-transfer: all state returns to reset values immediately. The in-flight word is dropped.

## Test plan
- Defaults, all-ones data:
  - Stimulus: inData = 64'hFFFF_FFFF_FFFF_FFFF, oddMode = 0, inParity = 4'b0000, outReady = 1.
  - Response: one cycle later outValid = 1, outLaneError = 0000, outError = 0, wordCount = 1, errorCount = 0.
- Even-mode single-lane error:
  - Stimulus: same data, oddMode = 0, inParity = 4'b0001.
  - Response: outLaneError = 0001, errorCount = 1, stickyError = 1, firstErrWord = 1, firstErrLanes = 0001.
- Odd-mode errors:
  - Stimulus: same data, oddMode = 1, inParity = 4'b0000.
  - Response: outLaneError = 1111.
  - Then inData = 64'h0000_0000_0000_0001 with inParity = 4'b1110.
  - Response: outLaneError = 0000, and firstErrWord is unchanged.
- Backpressure:
  - Stimulus: hold outReady = 0 for 3 cycles with inValid = 1.
  - Response: inReady = 0, outData is stable, wordCount increments only once. Release outReady and the next word is accepted in that cycle.
- Clear with simultaneous errored accept:
  - Stimulus: clearCounts = 1 in the same cycle as an accepted word with outError = 1.
  - Response: wordCount = 1, errorCount = 1, stickyError = 1, firstErrWord = 0.
- Saturation and reset:
  - Stimulus: CNT_WIDTH = 4, stream 20 errored words.
  - Response: wordCount = errorCount = 15 and they do not wrap.
  - Then assert reset mid-stream: all outputs return to 0 asynchronously, and inReady = 1.
